// File: rtl/conv.sv
// -----------------------------------------------------------------------------
// conv : 3x3 signed 2-D correlation datapath for the image-filter pipeline.
//
// A 3x3 kernel and a sliding 3x3 pixel window are built up one column at a
// time. A three-stage multiply/add pipeline runs on every clock and produces
// one scaled result per cycle. The result tracks whatever kernel/window pair
// is currently loaded. Deciding which results are written to memory is left
// to the controlling FSM outside this block.
//
// Input strobe: a column is accepted on a rising CLK100MHZ edge when i_valid
// is high. There is no ready/backpressure, because the block can always
// accept. i_selecK_I, sampled on the same edge, routes the column: 0 sends it
// to the kernel and 1 sends it to the window. With i_valid low, both the
// kernel and the window hold their contents.
//
// Ports:
//   CLK100MHZ  in   1          clock, all state on rising edge
//   i_reset    in   1          asynchronous, active-low reset
//   i_dato0    in   BIT_LEN    column element, row 0 (signed)
//   i_dato1    in   BIT_LEN    column element, row 1 (signed)
//   i_dato2    in   BIT_LEN    column element, row 2 (signed)
//   i_selecK_I in   1          0 = kernel column, 1 = image column
//   i_valid    in   1          column strobe
//   o_data     out  RAM_WIDTH  signed result, acc >>> (CONV_LEN-CONV_LPOS)
//
// Latency: o_data reflects the kernel/window state captured on edge E0
// starting just after edge E3 (products at E1, column sums at E2, output E3).
// M_LEN must be 3 and RAM_WIDTH must equal CONV_LPOS.
// -----------------------------------------------------------------------------
module conv #(
    parameter int BIT_LEN   = 8,
    parameter int CONV_LEN  = 20,
    parameter int CONV_LPOS = 13,
    parameter int M_LEN     = 3,
    parameter int RAM_WIDTH = 13
) (
    input  logic                 CLK100MHZ,
    input  logic                 i_reset,
    input  logic [BIT_LEN-1:0]   i_dato0,
    input  logic [BIT_LEN-1:0]   i_dato1,
    input  logic [BIT_LEN-1:0]   i_dato2,
    input  logic                 i_selecK_I,
    input  logic                 i_valid,
    output logic [RAM_WIDTH-1:0] o_data
);

    localparam int PROD_W = 2 * BIT_LEN;
    // The kernel is Q1.7 for 8-bit coefficients. Dropping the low bits
    // rescales the result back to pixel units.
    localparam int SHIFT  = CONV_LEN - CONV_LPOS;

    // Arrays are indexed [column][row]. Column 0 is the oldest column.
    logic signed [BIT_LEN-1:0]  kern    [M_LEN][M_LEN];
    logic signed [BIT_LEN-1:0]  win     [M_LEN][M_LEN];
    logic signed [BIT_LEN-1:0]  new_col [M_LEN];

    logic signed [PROD_W-1:0]   prod_d  [M_LEN][M_LEN];
    logic signed [PROD_W-1:0]   prod_q  [M_LEN][M_LEN];
    logic signed [CONV_LEN-1:0] csum_d  [M_LEN];
    logic signed [CONV_LEN-1:0] csum_q  [M_LEN];
    logic signed [CONV_LEN-1:0] acc_d;
    logic [RAM_WIDTH-1:0]       out_d;

    logic load_k;
    logic load_x;

    assign load_k = i_valid & ~i_selecK_I;
    assign load_x = i_valid &  i_selecK_I;

    always_comb begin
        new_col[0] = i_dato0;
        new_col[1] = i_dato1;
        new_col[2] = i_dato2;
    end

    // -------------------------------------------------------------------------
    // Kernel registers. Three kernel columns in a row fill the kernel, and the
    // first column sent ends up in column 0.
    // -------------------------------------------------------------------------
    always_ff @(posedge CLK100MHZ or negedge i_reset) begin
        if (!i_reset) begin
            for (int c = 0; c < M_LEN; c++) begin
                for (int r = 0; r < M_LEN; r++) begin
                    kern[c][r] <= '0;
                end
            end
        end else if (load_k) begin
            for (int c = 0; c < M_LEN - 1; c++) begin
                for (int r = 0; r < M_LEN; r++) begin
                    kern[c][r] <= kern[c+1][r];
                end
            end
            for (int r = 0; r < M_LEN; r++) begin
                kern[M_LEN-1][r] <= new_col[r];
            end
        end
    end

    // -------------------------------------------------------------------------
    // Pixel window. It uses the same shift rule as the kernel.
    // -------------------------------------------------------------------------
    always_ff @(posedge CLK100MHZ or negedge i_reset) begin
        if (!i_reset) begin
            for (int c = 0; c < M_LEN; c++) begin
                for (int r = 0; r < M_LEN; r++) begin
                    win[c][r] <= '0;
                end
            end
        end else if (load_x) begin
            for (int c = 0; c < M_LEN - 1; c++) begin
                for (int r = 0; r < M_LEN; r++) begin
                    win[c][r] <= win[c+1][r];
                end
            end
            for (int r = 0; r < M_LEN; r++) begin
                win[M_LEN-1][r] <= new_col[r];
            end
        end
    end

    // -------------------------------------------------------------------------
    // Stage 1: nine element-wise products. This is a correlation, so the
    // kernel is not flipped. The operands are sign-extended before the
    // multiply, which makes the PROD_W-bit result exact.
    // -------------------------------------------------------------------------
    always_comb begin
        for (int c = 0; c < M_LEN; c++) begin
            for (int r = 0; r < M_LEN; r++) begin
                prod_d[c][r] = PROD_W'(kern[c][r]) * PROD_W'(win[c][r]);
            end
        end
    end

    always_ff @(posedge CLK100MHZ or negedge i_reset) begin
        if (!i_reset) begin
            for (int c = 0; c < M_LEN; c++) begin
                for (int r = 0; r < M_LEN; r++) begin
                    prod_q[c][r] <= '0;
                end
            end
        end else begin
            for (int c = 0; c < M_LEN; c++) begin
                for (int r = 0; r < M_LEN; r++) begin
                    prod_q[c][r] <= prod_d[c][r];
                end
            end
        end
    end

    // -------------------------------------------------------------------------
    // Stage 2: per-column sums, sign-extended to the accumulator width.
    // -------------------------------------------------------------------------
    always_comb begin
        for (int c = 0; c < M_LEN; c++) begin
            csum_d[c] = '0;
            for (int r = 0; r < M_LEN; r++) begin
                csum_d[c] = csum_d[c] + CONV_LEN'(prod_q[c][r]);
            end
        end
    end

    always_ff @(posedge CLK100MHZ or negedge i_reset) begin
        if (!i_reset) begin
            for (int c = 0; c < M_LEN; c++) begin
                csum_q[c] <= '0;
            end
        end else begin
            for (int c = 0; c < M_LEN; c++) begin
                csum_q[c] <= csum_d[c];
            end
        end
    end

    // -------------------------------------------------------------------------
    // Stage 3: total and scale. The arithmetic shift truncates toward minus
    // infinity, and there is no rounding or saturation. The accumulator has
    // headroom for the worst case, 9 * (-128 * -128).
    // -------------------------------------------------------------------------
    always_comb begin
        acc_d = '0;
        for (int c = 0; c < M_LEN; c++) begin
            acc_d = acc_d + csum_q[c];
        end
        out_d = RAM_WIDTH'(acc_d >>> SHIFT);
    end

    always_ff @(posedge CLK100MHZ or negedge i_reset) begin
        if (!i_reset) begin
            o_data <= '0;
        end else begin
            o_data <= out_d;
        end
    end

endmodule

// File: tb/tb_conv.sv
module tb_conv;

    logic        CLK100MHZ;
    logic        i_reset;
    logic [7:0]  i_dato0;
    logic [7:0]  i_dato1;
    logic [7:0]  i_dato2;
    logic        i_selecK_I;
    logic        i_valid;
    logic [12:0] o_data;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference state, indexed [column][row], holding plain integers.
    int mk [3][3];
    int mx [3][3];
    logic [12:0] exp_q[$];

    conv dut (
        .CLK100MHZ (CLK100MHZ),
        .i_reset   (i_reset),
        .i_dato0   (i_dato0),
        .i_dato1   (i_dato1),
        .i_dato2   (i_dato2),
        .i_selecK_I(i_selecK_I),
        .i_valid   (i_valid),
        .o_data    (o_data)
    );

    // ---------------- clock / reset ----------------
    initial CLK100MHZ = 1'b0;
    always #5 CLK100MHZ = ~CLK100MHZ;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- checker ----------------
    task automatic check(input string tag, input logic [12:0] got, input logic [12:0] want);
        n_checks++;
        if (got === want) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d (0x%h) expected %0d (0x%h) at t=%0t",
                     tag, $signed(got), got, $signed(want), want, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [12:0] model_out();
        int acc = 0;
        for (int c = 0; c < 3; c++)
            for (int r = 0; r < 3; r++)
                acc += mk[c][r] * mx[c][r];
        return 13'(acc >>> 7);
    endfunction

    function automatic int rnd8();
        return int'($urandom_range(0, 255)) - 128;
    endfunction

    task automatic clear_model();
        for (int c = 0; c < 3; c++)
            for (int r = 0; r < 3; r++) begin
                mk[c][r] = 0;
                mx[c][r] = 0;
            end
        exp_q.delete();
        // The pipeline is all zeros after reset, so the first three
        // outputs are zero.
        repeat (3) exp_q.push_back(13'd0);
    endtask

    // ---------------- driver tasks ----------------
    // Drives one cycle. The model is updated for the edge, and the output
    // produced three edges earlier is compared.
    task automatic drive(input logic v, input logic s, input int r0, input int r1, input int r2);
        i_valid    = v;
        i_selecK_I = s;
        i_dato0    = 8'(r0);
        i_dato1    = 8'(r1);
        i_dato2    = 8'(r2);
        @(posedge CLK100MHZ);
        if (v) begin
            if (s) begin
                for (int c = 0; c < 2; c++)
                    for (int r = 0; r < 3; r++) mx[c][r] = mx[c+1][r];
                mx[2][0] = r0; mx[2][1] = r1; mx[2][2] = r2;
            end else begin
                for (int c = 0; c < 2; c++)
                    for (int r = 0; r < 3; r++) mk[c][r] = mk[c+1][r];
                mk[2][0] = r0; mk[2][1] = r1; mk[2][2] = r2;
            end
        end
        exp_q.push_back(model_out());
        #1;
        if (exp_q.size() > 3) check("pipe", o_data, exp_q.pop_front());
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            drive(1'b0, 1'($urandom_range(0, 1)), rnd8(), rnd8(), rnd8());
    endtask

    task automatic do_reset();
        i_valid    = 1'b1;
        i_selecK_I = 1'($urandom_range(0, 1));
        i_dato0    = 8'($urandom_range(0, 255));
        i_dato1    = 8'($urandom_range(0, 255));
        i_dato2    = 8'($urandom_range(0, 255));
        #2;
        i_reset = 1'b0;
        #1;
        check("rst_async", o_data, 13'd0);
        repeat (2) @(posedge CLK100MHZ);
        #1;
        check("rst_held", o_data, 13'd0);
        i_reset = 1'b1;
        clear_model();
    endtask

    task automatic center_tap();
        drive(1, 0, 0, 0, 0); drive(1, 0, 0, 64, 0);  drive(1, 0, 0, 0, 0);
        drive(1, 1, 0, 0, 0); drive(1, 1, 0, 100, 0); drive(1, 1, 0, 0, 0);
        idle(3);
        check("center", o_data, 13'd50);
        idle(2);
        check("center_hold", o_data, 13'd50);
    endtask

    task automatic random_run(input int n);
        for (int i = 0; i < n; i++)
            drive(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), rnd8(), rnd8(), rnd8());
    endtask

    // ---------------- stimulus ----------------
    initial begin
        i_reset    = 1'b0;
        i_valid    = 1'b0;
        i_selecK_I = 1'b0;
        i_dato0    = '0;
        i_dato1    = '0;
        i_dato2    = '0;

        do_reset();
        idle(4);

        center_tap();

        // Uniform: 9 * 16 * 8 = 1152, and 1152 >>> 7 = 9.
        repeat (3) drive(1, 0, 16, 16, 16);
        repeat (3) drive(1, 1, 8, 8, 8);
        idle(3);
        check("uniform", o_data, 13'd9);

        // Negative center tap: -64 * 100 = -6400, and -6400 >>> 7 = -50.
        drive(1, 0, 0, 0, 0); drive(1, 0, 0, -64, 0); drive(1, 0, 0, 0, 0);
        drive(1, 1, 0, 0, 0); drive(1, 1, 0, 100, 0); drive(1, 1, 0, 0, 0);
        idle(3);
        check("negative", o_data, 13'h1FCE);

        // Extreme: 9 * 16384 = 147456, and 147456 >>> 7 = 1152.
        repeat (3) drive(1, 0, -128, -128, -128);
        repeat (3) drive(1, 1, -128, -128, -128);
        idle(3);
        check("extreme", o_data, 13'd1152);

        // Sliding: only kernel col2/row1 is nonzero.
        drive(1, 0, 0, 0, 0); drive(1, 0, 0, 0, 0); drive(1, 0, 0, 64, 0);
        drive(1, 1, 0, 10, 0); drive(1, 1, 0, 20, 0);
        drive(1, 1, 0, 30, 0); drive(1, 1, 0, 40, 0);
        check("slide0", o_data, 13'd5);
        idle(1); check("slide1", o_data, 13'd10);
        idle(1); check("slide2", o_data, 13'd15);
        idle(1); check("slide3", o_data, 13'd20);

        // Gaps stretch the sequence.
        drive(1, 1, 0, 50, 0); idle(1); drive(1, 1, 0, 60, 0);
        check("gap0", o_data, 13'd20);
        idle(1); check("gap1", o_data, 13'd25);
        idle(1); check("gap2", o_data, 13'd25);
        idle(1); check("gap3", o_data, 13'd30);

        // A kernel column mid-stream moves the tap to col1 (pixel 60) and
        // leaves the window alone.
        drive(1, 1, 0, 70, 0);
        drive(1, 0, 0, 0, 0);
        idle(3);
        check("kprot", o_data, 13'd30);

        random_run(150);

        // Reset in the middle of activity, then reload.
        do_reset();
        idle(3);
        check("post_rst", o_data, 13'd0);
        center_tap();

        random_run(100);
        idle(3);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
